// File: rtl/esc_pkg.sv
// Shared constants, speed type and pulse-width helper for the ESC PWM generator.
package esc_pkg;

  localparam int SPEED_W_DEF    = 11;
  localparam int MIN_CLKS_DEF   = 6250;
  localparam int SCALE_DEF      = 3;
  localparam int FRAME_CLKS_DEF = 15000;
  localparam int SPD_MAX_DEF    = 2047;
  localparam int SLEW_STEP_DEF  = 64;

  typedef logic [SPEED_W_DEF-1:0] speed_t;

  // Pulse width in clocks for a given (already clamped) speed.
  function automatic int unsigned calc_width(input int unsigned speed,
                                             input int unsigned min_clks,
                                             input int unsigned scale);
    return min_clks + scale * speed;
  endfunction

endpackage

// File: rtl/esc_pwm_chan.sv
// One ESC channel: shadow speed, frame-boundary width update and pulse compare.
// Define ESC_SLEW_LIMIT_EN to rate-limit the applied speed by SLEW_STEP per frame.
module esc_pwm_chan
  import esc_pkg::*;
#(
  parameter int SPEED_W   = SPEED_W_DEF,
  parameter int MIN_CLKS  = MIN_CLKS_DEF,
  parameter int SCALE     = SCALE_DEF,
  parameter int SPD_MAX   = SPD_MAX_DEF,
  parameter int SLEW_STEP = SLEW_STEP_DEF,
  parameter int CNT_W     = 14
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wrt_q,
  input  logic [SPEED_W-1:0] speed_q,
  input  logic               wrap,
  input  logic               en_next,
  input  logic               en_frame,
  input  logic [CNT_W-1:0]   cnt,
  output logic               pwm
);

  localparam int WW = CNT_W + 1;

  logic [SPEED_W-1:0] spd_clamped;
  logic [SPEED_W-1:0] shadow_reg;
  logic [SPEED_W-1:0] shadow_next;
  logic [SPEED_W-1:0] width_src;
  logic [WW-1:0]      width_next;
  logic [WW-1:0]      active_w_reg;
  logic               pwm_reg;

  if (SLEW_STEP < 1) begin : g_step_check
    $error("esc_pwm_chan: SLEW_STEP must be at least 1");
  end

  always_comb begin
    spd_clamped = speed_q;
    if (32'(speed_q) > 32'(SPD_MAX)) begin
      spd_clamped = SPEED_W'(SPD_MAX);
    end
    // A write landing on the wrap cycle must already count for the coming frame.
    shadow_next = wrt_q ? spd_clamped : shadow_reg;
  end

`ifdef ESC_SLEW_LIMIT_EN
  logic [SPEED_W-1:0] app_reg;
  logic [SPEED_W-1:0] app_next;

  always_comb begin
    app_next = shadow_next;
    if (shadow_next > app_reg) begin
      if (32'(shadow_next - app_reg) > 32'(SLEW_STEP)) begin
        app_next = app_reg + SPEED_W'(SLEW_STEP);
      end
    end else if (32'(app_reg - shadow_next) > 32'(SLEW_STEP)) begin
      app_next = app_reg - SPEED_W'(SLEW_STEP);
    end
  end

  // Disabled frames freeze the ramp so re-enabling resumes from the same point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      app_reg <= '0;
    end else if (wrap && en_next) begin
      app_reg <= app_next;
    end
  end

  assign width_src = app_next;
`else
  assign width_src = shadow_next;
`endif

  assign width_next = en_next ? WW'(calc_width(32'(width_src), MIN_CLKS, SCALE)) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg   <= '0;
      active_w_reg <= '0;
      pwm_reg      <= 1'b0;
    end else begin
      shadow_reg <= shadow_next;
      if (wrap) begin
        active_w_reg <= width_next;
      end
      pwm_reg <= en_frame && ({1'b0, cnt} < active_w_reg);
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/esc_pwm_multi.sv
// Multi-channel ESC PWM generator: one shared frame counter, NUM_CH glitch-free channels.
// Optional macro ESC_SLEW_LIMIT_EN enables per-channel slew limiting (see esc_pwm_chan).
module esc_pwm_multi
  import esc_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SPEED_W    = SPEED_W_DEF,
  parameter int MIN_CLKS   = MIN_CLKS_DEF,
  parameter int SCALE      = SCALE_DEF,
  parameter int SPD_MAX    = SPD_MAX_DEF,
  parameter int FRAME_CLKS = FRAME_CLKS_DEF,
  parameter int SLEW_STEP  = SLEW_STEP_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         wrt,
  input  logic [NUM_CH*SPEED_W-1:0] speed,
  input  logic                      enable,
  output logic [NUM_CH-1:0]         pwm,
  output logic                      frame_start
);

  localparam int CNT_W = $clog2(FRAME_CLKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CLKS - 1);

  logic [NUM_CH-1:0]         wrt_q_reg;
  logic [NUM_CH*SPEED_W-1:0] speed_q_reg;
  logic [CNT_W-1:0]          cnt_reg;
  logic [CNT_W-1:0]          cnt_next;
  logic                      en_reg;
  logic                      frame_start_reg;
  logic                      wrap;

  // The longest pulse must leave a low gap before the next frame's rising edge.
  if (MIN_CLKS + SCALE * SPD_MAX >= FRAME_CLKS) begin : g_range_check
    $error("esc_pwm_multi: MIN_CLKS + SCALE*SPD_MAX must be below FRAME_CLKS");
  end

  assign wrap     = (cnt_reg == CNT_LAST);
  assign cnt_next = wrap ? '0 : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_q_reg       <= '0;
      speed_q_reg     <= '0;
      cnt_reg         <= '0;
      en_reg          <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      wrt_q_reg       <= wrt;
      speed_q_reg     <= speed;
      cnt_reg         <= cnt_next;
      frame_start_reg <= wrap;
      if (wrap) begin
        en_reg <= enable;
      end
    end
  end

  assign frame_start = frame_start_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    esc_pwm_chan #(
      .SPEED_W  (SPEED_W),
      .MIN_CLKS (MIN_CLKS),
      .SCALE    (SCALE),
      .SPD_MAX  (SPD_MAX),
      .SLEW_STEP(SLEW_STEP),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .wrt_q   (wrt_q_reg[gi]),
      .speed_q (speed_q_reg[gi*SPEED_W +: SPEED_W]),
      .wrap    (wrap),
      .en_next (enable),
      .en_frame(en_reg),
      .cnt     (cnt_reg),
      .pwm     (pwm[gi])
    );
  end

endmodule
